serial_bus_arbiter: RTL and testbench
=====================================

# serial_bus_arbiter

Shares one serial-bus slave port between `N_MASTERS` bus masters. Masters request the bus, and the block grants it to one at a time in round-robin order. While a master holds the grant, its bit-serial address/data lines and control strobes go to the slave port, and the slave's responses go back only to that master. A timeout counter reclaims the bus from a master that never signals completion.

## Interface
- `N_MASTERS`, 2: number of requesting masters (2..8).
- `TIMEOUT`, 64: maximum number of cycles one grant may last before it is forcibly revoked.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_MASTERS  per-master bus request; level, held for the whole transaction.
- `done`  in  N_MASTERS  per-master one-cycle pulse marking the end of its transaction.
- `grant`  out  N_MASTERS  one-hot grant, registered; all-zero when the bus is idle.
- `m_valid_in`, `m_write_enable`, `m_read_enable`, `m_rx_address`, `m_rx_data`  in  N_MASTERS each  per-master bus-driving signals.
- `bus_m_valid`, `bus_write_enable`, `bus_read_enable`, `bus_rx_address`, `bus_rx_data`  out  1 each  muxed signals to the slave port.
- `bus_s_valid`, `bus_s_ready`, `bus_tx_data`  in  1 each  slave-port responses.
- `s_valid_out`, `s_ready_out`, `tx_data_out`  out  N_MASTERS each  responses routed to the granted master.
- `busy`  out  1  high whenever any grant bit is set.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- State machine with three states: IDLE, GRANT, RELEASE.
- **IDLE:**
  - If `req` is nonzero, pick the first requester starting from the round-robin pointer `ptr` and searching upward with wrap-around.
  - Load that master's one-hot value into `grant`, clear the timeout counter, and go to GRANT.
- **GRANT:**
  - Leave GRANT when the granted master pulses `done`, drops `req`, or the counter reaches `TIMEOUT-1`.
  - On exit, go to RELEASE, clear `grant`, and set `ptr` to the granted index + 1 modulo N_MASTERS.
  - Otherwise, increment the counter.
- **RELEASE:** one dead cycle with the bus quiet, then go to IDLE unconditionally.
- **Forward path:** bus outputs equal the granted master's inputs. With no grant, every bus output is 0.
- **Return path:**
  - Only the granted master's bit of `s_valid_out`, `s_ready_out` and `tx_data_out` follows the slave inputs.
  - All other bits are held at 0.
- **Counter:** width `$clog2(TIMEOUT)`, saturating. It never wraps.
- **Ignored inputs:** `done` from masters that are not granted is ignored.
- **Simultaneous events:**
  - `done` and timeout in the same cycle: normal release, `timeout_err` stays 0.
  - Several requests in IDLE: the lowest index at or above `ptr` (modulo N_MASTERS) wins.

## Timing
- **Reset values:**
  - state IDLE, `ptr` 0, `grant` 0, counter 0.
  - `busy` 0, `timeout_err` 0.
  - All bus outputs and all `*_out` signals 0.
- **Grant latency:** `req` sampled in IDLE on edge t gives `grant` high after edge t+1. `busy` follows on the same edge.
- **Release:** `done` sampled on edge t drops `grant` after edge t+1 (RELEASE). The state is IDLE after t+2, and the next grant appears after t+3 at the earliest.
- **Timeout:** the first cycle of GRANT has counter 0. On the cycle the counter equals `TIMEOUT-1`, the next edge drops `grant` and `timeout_err` is high for exactly one cycle.
- **Mux paths:** forward and return muxes are combinational on the registered `grant`, so bit-serial data passes with zero added latency.
- **Reset during GRANT:** `grant` and every muxed output go to 0 on the same edge. No `timeout_err` is produced.

## Structure
- Shared package `serial_bus_pkg` holds:
  - `arb_state_t`, enum {IDLE, GRANT, RELEASE}.
  - `ADDR_WIDTH` = 12 and `DATA_WIDTH` = 8, shared with the slave port.
- One sub-module, `rr_priority_picker`:
  - Combinational. Takes `req` and `ptr`, returns a one-hot winner and its index.
  - Parameterised by N_MASTERS.
- The FSM, counter, `ptr` register and muxes live in `serial_bus_arbiter`.

## Test plan
- **Reset:** hold `rst` 3 cycles with `req`=2'b11 → `grant`=0, `busy`=0, all bus outputs 0. After release, the first grant is 2'b01 one cycle later.
- **Round-robin with both requesting:**
  - Master 0 pulses `done` at its 5th grant cycle → `grant` 0 for 2 cycles, then `grant`=2'b10.
  - Master 1 then finishes → `grant`=2'b01.
- **Pass-through:**
  - Master 1 granted, drives the 12-bit address 0xB35 serially on `m_rx_address[1]` → `bus_rx_address` matches bit-for-bit with the same cycle alignment.
  - Slave response on `bus_tx_data` with 0xCC → appears only on `tx_data_out[1]`; `tx_data_out[0]` stays 0.
- **Timeout:** `TIMEOUT`=64, master 0 holds `req` with no `done` → `grant` drops after exactly 64 cycles and `timeout_err` pulses once.
  - Same setup but `done` arrives in the 64th cycle → normal release, no `timeout_err`.
- **Early drop and stray done:**
  - Master 0 drops `req` mid-grant without `done` → release through RELEASE.
  - Stray `done[1]` while master 0 is granted → no effect.
- **Reset mid-transfer:** assert `rst` during a write with the bus active → all outputs 0 on the next edge, and `ptr` returns to 0.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// serial_bus_pkg
// Shared definitions for the serial-bus arbiter and the slave port it feeds.
//   arb_state_t : arbiter FSM states (IDLE, GRANT, RELEASE)
//   ADDR_WIDTH  : bit length of one serial address word on the slave port
//   DATA_WIDTH  : bit length of one serial data word on the slave port
package serial_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 8;

endpackage

// File: rtl/serial_bus_arbiter_picker.sv
// rr_priority_picker
// Combinational round-robin search: starting at ptr_i and moving upward with
// wrap-around, returns the first set bit of req_i.
//   req_i        : per-master request vector
//   ptr_i        : index where the search starts
//   winner_o     : one-hot winning master (all-zero when nothing requests)
//   winner_idx_o : binary index of the winner (0 when nothing requests)
//   found_o      : high when at least one master requests
module rr_priority_picker
  import serial_bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  localparam int IDX_W = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [N_MASTERS-1:0] winner_o,
  output logic [IDX_W-1:0]     winner_idx_o,
  output logic                 found_o
);

  int cand;

  // Walk the offsets from farthest to nearest so that the candidate closest
  // to the pointer is the last one written and therefore wins.
  always_comb begin
    winner_o     = '0;
    winner_idx_o = '0;
    found_o      = 1'b0;
    cand         = 0;
    for (int off = N_MASTERS - 1; off >= 0; off--) begin
      cand = int'(ptr_i) + off;
      if (cand >= N_MASTERS) begin
        cand = cand - N_MASTERS;
      end
      if (req_i[IDX_W'(cand)]) begin
        winner_o                = '0;
        winner_o[IDX_W'(cand)]  = 1'b1;
        winner_idx_o            = IDX_W'(cand);
        found_o                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter
// Round-robin owner of a single serial-bus slave port shared by N_MASTERS
// masters, with a timeout that reclaims the bus from a stuck master.
//   clk, rst              : clock, synchronous active-high reset
//   req, done             : per-master request level / end-of-transaction pulse
//   grant, busy           : registered one-hot grant and its OR
//   timeout_err           : one-cycle pulse when a grant is revoked by timeout
//   m_* (in)              : per-master bit-serial lines towards the slave
//   bus_* (out)           : the granted master's lines, 0 when idle
//   bus_s_valid/ready/tx  : slave responses
//   *_out                 : slave responses steered to the granted master only
module serial_bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] done,
  output logic [N_MASTERS-1:0] grant,
  input  logic [N_MASTERS-1:0] m_valid_in,
  input  logic [N_MASTERS-1:0] m_write_enable,
  input  logic [N_MASTERS-1:0] m_read_enable,
  input  logic [N_MASTERS-1:0] m_rx_address,
  input  logic [N_MASTERS-1:0] m_rx_data,
  output logic                 bus_m_valid,
  output logic                 bus_write_enable,
  output logic                 bus_read_enable,
  output logic                 bus_rx_address,
  output logic                 bus_rx_data,
  input  logic                 bus_s_valid,
  input  logic                 bus_s_ready,
  input  logic                 bus_tx_data,
  output logic [N_MASTERS-1:0] s_valid_out,
  output logic [N_MASTERS-1:0] s_ready_out,
  output logic [N_MASTERS-1:0] tx_data_out,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_MASTERS - 1);

  arb_state_t           state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 terr_q, terr_d;

  logic [N_MASTERS-1:0] pickWinner;
  logic [IDX_W-1:0]     pickIdx;
  logic                 pickFound;

  logic ownerDone;
  logic ownerGone;
  logic cntAtLast;

  rr_priority_picker #(
    .N_MASTERS (N_MASTERS)
  ) u_picker (
    .req_i        (req),
    .ptr_i        (ptr_q),
    .winner_o     (pickWinner),
    .winner_idx_o (pickIdx),
    .found_o      (pickFound)
  );

  // Only the current owner's done/req matter; anything from other masters
  // is masked away by the one-hot grant.
  assign ownerDone = |(done & grant_q);
  assign ownerGone = ~|(req & grant_q);
  assign cntAtLast = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickFound) begin
          grant_d = pickWinner;
          idx_d   = pickIdx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (ownerDone || ownerGone || cntAtLast) begin
          state_d = RELEASE;
          grant_d = '0;
          ptr_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          // A master that finishes on its last allowed cycle is a normal
          // release, not a timeout.
          terr_d  = cntAtLast && !ownerDone && !ownerGone;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  // Muxes are purely combinational on the registered one-hot grant, so
  // serial bits cross the arbiter in the same cycle they are driven.
  assign bus_m_valid      = |(m_valid_in & grant_q);
  assign bus_write_enable = |(m_write_enable & grant_q);
  assign bus_read_enable  = |(m_read_enable & grant_q);
  assign bus_rx_address   = |(m_rx_address & grant_q);
  assign bus_rx_data      = |(m_rx_data & grant_q);

  assign s_valid_out = grant_q & {N_MASTERS{bus_s_valid}};
  assign s_ready_out = grant_q & {N_MASTERS{bus_s_ready}};
  assign tx_data_out = grant_q & {N_MASTERS{bus_tx_data}};

  assign grant       = grant_q;
  assign busy        = |grant_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb_serial_bus_arbiter
// Directed bench for serial_bus_arbiter (2 masters, timeout 64). A reference
// model tracks bus ownership from the arbitration rules and is compared with
// the DUT every cycle; directed checks pin specific hand-computed values.
module tb_serial_bus_arbiter;

  localparam int N       = 2;
  localparam int TIMEOUT = 64;
  localparam logic [N-1:0] ONE = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, done;
  logic [N-1:0] grant;
  logic [N-1:0] m_valid_in, m_write_enable, m_read_enable, m_rx_address, m_rx_data;
  logic         bus_m_valid, bus_write_enable, bus_read_enable, bus_rx_address, bus_rx_data;
  logic         bus_s_valid, bus_s_ready, bus_tx_data;
  logic [N-1:0] s_valid_out, s_ready_out, tx_data_out;
  logic         busy, timeout_err;

  int testsRun = 0;
  int testsFailed = 0;

  serial_bus_arbiter #(
    .N_MASTERS (N),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .done             (done),
    .grant            (grant),
    .m_valid_in       (m_valid_in),
    .m_write_enable   (m_write_enable),
    .m_read_enable    (m_read_enable),
    .m_rx_address     (m_rx_address),
    .m_rx_data        (m_rx_data),
    .bus_m_valid      (bus_m_valid),
    .bus_write_enable (bus_write_enable),
    .bus_read_enable  (bus_read_enable),
    .bus_rx_address   (bus_rx_address),
    .bus_rx_data      (bus_rx_data),
    .bus_s_valid      (bus_s_valid),
    .bus_s_ready      (bus_s_ready),
    .bus_tx_data      (bus_tx_data),
    .s_valid_out      (s_valid_out),
    .s_ready_out      (s_ready_out),
    .tx_data_out      (tx_data_out),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bitAt(input logic [N-1:0] v, input int k);
    logic [N-1:0] t;
    t = v >> k;
    return t[0];
  endfunction

  // Reference model: who owns the bus, for how many cycles, how many quiet
  // cycles remain before arbitration resumes, and where the search starts.
  int mOwner = -1;
  int mAge = 0;
  int mCool = 0;
  int mPtr = 0;
  bit mTerr = 1'b0;
  bit modelValid = 1'b0;

  task automatic advanceModel();
    bit finished, expired;
    int k;
    if (rst) begin
      mOwner = -1; mAge = 0; mCool = 0; mPtr = 0; mTerr = 1'b0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      mTerr = 1'b0;
      if (mOwner >= 0) begin
        finished = bitAt(done, mOwner) || !bitAt(req, mOwner);
        expired  = (mAge == TIMEOUT - 1);
        if (finished || expired) begin
          mTerr  = expired && !finished;
          mPtr   = (mOwner + 1) % N;
          mOwner = -1;
          mCool  = 1;
        end else begin
          mAge++;
        end
      end else if (mCool > 0) begin
        mCool--;
      end else begin
        for (int i = 0; i < N; i++) begin
          k = (mPtr + i) % N;
          if (mOwner < 0 && bitAt(req, k)) begin
            mOwner = k;
            mAge   = 0;
          end
        end
      end
    end
  endtask

  always @(posedge clk) advanceModel();

  // Every-cycle comparison of DUT outputs against the model, mid-cycle.
  always @(negedge clk) begin
    logic [N-1:0] expOh;
    logic [4:0]   expFwd;
    if (modelValid) begin
      expOh  = (mOwner >= 0) ? (ONE << mOwner) : '0;
      expFwd = (mOwner >= 0) ? {bitAt(m_valid_in, mOwner), bitAt(m_write_enable, mOwner),
                                bitAt(m_read_enable, mOwner), bitAt(m_rx_address, mOwner),
                                bitAt(m_rx_data, mOwner)} : 5'b0;
      checkOutput("grant", grant, expOh);
      checkOutput("busy", busy, mOwner >= 0);
      checkOutput("timeout_err", timeout_err, mTerr);
      checkOutput("fwd_bus", {bus_m_valid, bus_write_enable, bus_read_enable,
                              bus_rx_address, bus_rx_data}, expFwd);
      checkOutput("s_valid_out", s_valid_out, expOh & {N{bus_s_valid}});
      checkOutput("s_ready_out", s_ready_out, expOh & {N{bus_s_ready}});
      checkOutput("tx_data_out", tx_data_out, expOh & {N{bus_tx_data}});
    end
  end

  // Drive req/done for one cycle, then return just after the next edge.
  task automatic applyStimulus(input logic [N-1:0] reqV, input logic [N-1:0] doneV);
    req  = reqV;
    done = doneV;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] addrVal;
    logic [11:0] addrCap;
    logic [7:0]  dataVal;
    logic [7:0]  txCap;
    logic        tx0Seen;
    int          hi;

    rst = 1'b1; req = 2'b11; done = 2'b00;
    m_valid_in = 2'b11; m_write_enable = 2'b11; m_read_enable = 2'b00;
    m_rx_address = 2'b11; m_rx_data = 2'b11;
    bus_s_valid = 1'b1; bus_s_ready = 1'b1; bus_tx_data = 1'b1;

    // Reset held 3 cycles with both masters requesting
    repeat (3) applyStimulus(2'b11, 2'b00);
    checkOutput("rst_grant", grant, 2'b00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_bus", {bus_m_valid, bus_write_enable, bus_rx_address, bus_rx_data}, 4'h0);
    checkOutput("rst_ret", {s_valid_out, s_ready_out, tx_data_out}, 6'h0);
    m_valid_in = '0; m_write_enable = '0; m_rx_address = '0; m_rx_data = '0;
    bus_s_valid = 1'b0; bus_s_ready = 1'b0; bus_tx_data = 1'b0;
    rst = 1'b0;
    applyStimulus(2'b11, 2'b00);
    checkOutput("first_grant", grant, 2'b01);

    // Round robin: master 0 finishes in its 5th grant cycle
    repeat (4) applyStimulus(2'b11, 2'b00);
    applyStimulus(2'b11, 2'b01);
    checkOutput("rr_gap1", grant, 2'b00);
    applyStimulus(2'b11, 2'b00);
    checkOutput("rr_gap2", grant, 2'b00);
    applyStimulus(2'b11, 2'b00);
    checkOutput("rr_to_m1", grant, 2'b10);
    applyStimulus(2'b11, 2'b10);
    applyStimulus(2'b11, 2'b00);
    applyStimulus(2'b11, 2'b00);
    checkOutput("rr_back_m0", grant, 2'b01);

    // Pass-through with master 1 owning the bus
    applyStimulus(2'b11, 2'b01);
    applyStimulus(2'b11, 2'b00);
    applyStimulus(2'b11, 2'b00);
    checkOutput("pt_m1_grant", grant, 2'b10);
    addrVal = 12'hB35;
    addrCap = '0;
    for (int i = 11; i >= 0; i--) begin
      m_valid_in     = 2'b10;
      m_write_enable = 2'b10;
      m_rx_address   = {addrVal[i], ~addrVal[i]};
      m_rx_data      = 2'($urandom_range(0, 3));
      #1;
      addrCap = {addrCap[10:0], bus_rx_address};
      applyStimulus(2'b11, 2'b00);
    end
    checkOutput("addr_b35", addrCap, 12'hB35);
    m_valid_in = '0; m_write_enable = '0; m_rx_address = '0; m_rx_data = '0;
    dataVal = 8'hCC;
    txCap   = '0;
    tx0Seen = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      bus_s_valid = 1'b1;
      bus_tx_data = dataVal[i];
      #1;
      txCap   = {txCap[6:0], tx_data_out[1]};
      tx0Seen = tx0Seen | tx_data_out[0];
      applyStimulus(2'b11, 2'b00);
    end
    checkOutput("tx_m1_cc", txCap, 8'hCC);
    checkOutput("tx_m0_quiet", tx0Seen, 1'b0);
    bus_s_valid = 1'b0; bus_tx_data = 1'b0;

    // Timeout: master 0 holds req with no done
    applyStimulus(2'b01, 2'b10);
    applyStimulus(2'b01, 2'b00);
    applyStimulus(2'b01, 2'b00);
    checkOutput("to_start", grant, 2'b01);
    hi = 0;
    while (grant == 2'b01 && hi < 100) begin
      hi++;
      applyStimulus(2'b01, 2'b00);
    end
    checkOutput("to_len", hi, 64);
    checkOutput("to_pulse", timeout_err, 1'b1);
    applyStimulus(2'b00, 2'b00);
    checkOutput("to_once", timeout_err, 1'b0);

    // done in the 64th grant cycle is a normal release
    applyStimulus(2'b01, 2'b00);
    checkOutput("late_start", grant, 2'b01);
    repeat (63) applyStimulus(2'b01, 2'b00);
    applyStimulus(2'b01, 2'b01);
    checkOutput("late_done_rel", grant, 2'b00);
    checkOutput("late_done_noerr", timeout_err, 1'b0);
    applyStimulus(2'b00, 2'b00);
    applyStimulus(2'b00, 2'b00);

    // Stray done from a non-owner, then early req drop
    applyStimulus(2'b01, 2'b00);
    applyStimulus(2'b01, 2'b10);
    checkOutput("stray_done", grant, 2'b01);
    applyStimulus(2'b00, 2'b00);
    checkOutput("early_drop", grant, 2'b00);
    checkOutput("early_drop_noerr", timeout_err, 1'b0);
    applyStimulus(2'b00, 2'b00);

    // Reset in the middle of a write by master 1
    applyStimulus(2'b10, 2'b00);
    checkOutput("m1_before_rst", grant, 2'b10);
    m_valid_in = 2'b10; m_write_enable = 2'b10; m_rx_data = 2'b10;
    bus_s_ready = 1'b1; bus_s_valid = 1'b1;
    #1;
    checkOutput("wr_active", bus_write_enable, 1'b1);
    rst = 1'b1;
    applyStimulus(2'b10, 2'b00);
    checkOutput("rst_mid_grant", grant, 2'b00);
    checkOutput("rst_mid_bus", {bus_m_valid, bus_write_enable, bus_rx_data}, 3'b000);
    checkOutput("rst_mid_ret", {s_valid_out, s_ready_out}, 4'h0);
    checkOutput("rst_mid_noerr", timeout_err, 1'b0);
    rst = 1'b0;
    m_valid_in = '0; m_write_enable = '0; m_rx_data = '0;
    bus_s_ready = 1'b0; bus_s_valid = 1'b0;
    applyStimulus(2'b11, 2'b00);
    checkOutput("ptr_reset", grant, 2'b01);
    applyStimulus(2'b00, 2'b00);
    applyStimulus(2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
